// File: rtl/replay_ctrl.sv
// Record/playback sequencer for the 512x8 replay FIFO: records one terminated RX line,
// replays it repeat_count times to TX, then erases. Optional feature macro: REPLAY_LF_EN.
module replay_ctrl #(
    parameter logic [7:0]  TERM_CHAR = 8'h0D,
    parameter int unsigned MAX_LEN   = 511,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [CNT_W-1:0] repeat_count,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       fifo_wdata,
    output logic             fifo_write,
    output logic             fifo_read,
    output logic             fifo_replay,
    output logic             fifo_erase,
    input  logic [7:0]       fifo_rdata,
    input  logic             fifo_emptyB,
    output logic             busy,
    output logic             overflow,
    output logic             done
);

    localparam int unsigned      LEN_W     = 9;
    localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RECORD,
        REPLAY,
        READ,
        WAIT,
        SEND,
        ERASE
`ifdef REPLAY_LF_EN
        , SEPLF
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len, len_nxt;
    logic [CNT_W-1:0] pass, pass_nxt;
    logic             overflow_nxt;
    logic [7:0]       tx_data_nxt;
    logic             tx_valid_nxt;
    logic [CNT_W-1:0] pass_load;
    logic             pass_last;

    // A repeat count of zero still plays the line once.
    assign pass_load  = (repeat_count == '0) ? CNT_W'(1) : repeat_count;
    assign pass_last  = (pass <= CNT_W'(1));
    assign fifo_wdata = rx_data;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            len      <= '0;
            pass     <= '0;
            overflow <= 1'b0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            len      <= len_nxt;
            pass     <= pass_nxt;
            overflow <= overflow_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        len_nxt      = len;
        pass_nxt     = pass;
        overflow_nxt = overflow;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        rx_ready     = 1'b0;
        fifo_write   = 1'b0;
        fifo_read    = 1'b0;
        fifo_replay  = 1'b0;
        fifo_erase   = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    fifo_write   = 1'b1;
                    overflow_nxt = 1'b0;
                    len_nxt      = LEN_W'(1);
                    if (rx_data == TERM_CHAR) begin
                        pass_nxt  = pass_load;
                        state_nxt = REPLAY;
                    end else begin
                        state_nxt = RECORD;
                    end
                end
            end
            RECORD: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    // One slot is always kept free so the terminator fits.
                    if (rx_data == TERM_CHAR) begin
                        fifo_write = 1'b1;
                        len_nxt    = len + LEN_W'(1);
                        pass_nxt   = pass_load;
                        state_nxt  = REPLAY;
                    end else if (len < LEN_LIMIT) begin
                        fifo_write = 1'b1;
                        len_nxt    = len + LEN_W'(1);
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end
            end
            REPLAY: begin
                fifo_replay = 1'b1;
                state_nxt   = READ;
            end
            READ: begin
                if (fifo_emptyB) begin
                    fifo_read = 1'b1;
                    state_nxt = WAIT;
                end else begin
`ifdef REPLAY_LF_EN
                    tx_data_nxt  = 8'h0A;
                    tx_valid_nxt = 1'b1;
                    state_nxt    = SEPLF;
`else
                    pass_nxt  = pass - CNT_W'(1);
                    state_nxt = pass_last ? ERASE : REPLAY;
`endif
                end
            end
            WAIT: begin
                tx_data_nxt  = fifo_rdata;
                tx_valid_nxt = 1'b1;
                state_nxt    = SEND;
            end
            SEND: begin
                if (tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = READ;
                end
            end
`ifdef REPLAY_LF_EN
            SEPLF: begin
                if (tx_ready) begin
                    tx_valid_nxt = 1'b0;
                    pass_nxt     = pass - CNT_W'(1);
                    state_nxt    = pass_last ? ERASE : REPLAY;
                end
            end
`endif
            ERASE: begin
                fifo_erase = 1'b1;
                done       = 1'b1;
                len_nxt    = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
